iir_biquad_scheduler: RTL and testbench

//  Time-multiplexes one shared biquad multiply-accumulate datapath across NSEC cascaded

---
 rtl/iir_biquad_scheduler_if.sv | 30 +++
 rtl/iir_biquad_scheduler.sv | 151 +++++++++++++++
 tb/tb_iir_biquad_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_biquad_scheduler_if.sv
// Sample-in / sample-out handshake plus coefficient write port of the time-multiplexed biquad cascade.
// The filter itself connects through the slave modport.
interface iir_biquad_scheduler_if #(
  parameter int W    = 32,
  parameter int NSEC = 22
);
  localparam int CA = $clog2(NSEC * 5);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          coef_we;
  logic [CA-1:0] coef_addr;
  logic [W-1:0]  coef_wdata;
  logic          coef_err;
  logic          busy;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, coef_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, coef_err, busy
  );
endinterface

// File: rtl/iir_biquad_scheduler.sv
// NSEC Direct Form I biquad sections sharing one MAC, one coefficient RAM and one state RAM.
// Define IIR_SAT_EN to clamp each section result to W bits instead of wrapping.
module iir_biquad_scheduler #(
  parameter int W    = 32,
  parameter int FSW  = 16,
  parameter int NSEC = 22
) (
  input logic                    clk,
  input logic                    rst,
  iir_biquad_scheduler_if.slave  bus
);
  localparam int CA    = $clog2(NSEC * 5);
  localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int AW    = 2 * W + 3;
  localparam int NCOEF = NSEC * 5;

  typedef enum logic [2:0] {INIT, IDLE, MAC, WB, OUT} state_t;

  logic [W-1:0] coef_ram [NCOEF];
  logic [W-1:0] x1_ram [NSEC];
  logic [W-1:0] x2_ram [NSEC];
  logic [W-1:0] y1_ram [NSEC];
  logic [W-1:0] y2_ram [NSEC];

  state_t                state;
  logic [SW-1:0]         sec;
  logic [SW-1:0]         init_cnt;
  logic [2:0]            k;
  logic signed [W-1:0]   x;
  logic signed [AW-1:0]  acc;

  logic [CA-1:0]          coef_idx;
  logic signed [W-1:0]    cur_coef;
  logic signed [W-1:0]    cur_op;
  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [W-1:0]    y_res;
  logic                   coef_ok;

`ifdef IIR_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  logic signed [AW-1:0] y_full;
`endif

  // k walks b0,b1,b2,a1,a2 so the coefficient and its matching sample/state line up each cycle
  always_comb begin
    coef_idx = CA'(32'(sec) * 5 + 32'(k));
    cur_coef = $signed(coef_ram[coef_idx]);
    case (k)
      3'd0:    cur_op = x;
      3'd1:    cur_op = $signed(x1_ram[sec]);
      3'd2:    cur_op = $signed(x2_ram[sec]);
      3'd3:    cur_op = $signed(y1_ram[sec]);
      default: cur_op = $signed(y2_ram[sec]);
    endcase
    prod     = cur_coef * cur_op;
    prod_ext = $signed({{(AW-2*W){prod[2*W-1]}}, prod});
`ifdef IIR_SAT_EN
    y_full = acc >>> FSW;
    if (y_full > Y_MAX)
      y_res = {1'b0, {(W-1){1'b1}}};
    else if (y_full < Y_MIN)
      y_res = {1'b1, {(W-1){1'b0}}};
    else
      y_res = y_full[W-1:0];
`else
    y_res = W'(acc >>> FSW);
`endif
    coef_ok = (state == IDLE) && (32'(bus.coef_addr) < 32'(NCOEF));
  end

  // Coefficient writes commit before the MAC of a sample accepted on the same edge can read them
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      init_cnt      <= '0;
      sec           <= '0;
      k             <= '0;
      x             <= '0;
      acc           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.coef_err  <= 1'b0;
      bus.busy      <= 1'b1;
    end else begin
      bus.coef_err <= bus.coef_we && !coef_ok;
      if (bus.coef_we && coef_ok)
        coef_ram[bus.coef_addr] <= bus.coef_wdata;

      case (state)
        INIT: begin
          x1_ram[init_cnt] <= '0;
          x2_ram[init_cnt] <= '0;
          y1_ram[init_cnt] <= '0;
          y2_ram[init_cnt] <= '0;
          if (init_cnt == SW'(NSEC - 1)) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.in_valid) begin
            x            <= $signed(bus.in_data);
            sec          <= '0;
            k            <= '0;
            state        <= MAC;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        MAC: begin
          acc <= ((k == 3'd0) ? {AW{1'b0}} : acc) + ((k >= 3'd3) ? -prod_ext : prod_ext);
          if (k == 3'd4)
            state <= WB;
          else
            k <= k + 3'd1;
        end
        WB: begin
          x1_ram[sec] <= x;
          x2_ram[sec] <= x1_ram[sec];
          y1_ram[sec] <= y_res;
          y2_ram[sec] <= y1_ram[sec];
          x           <= y_res;
          k           <= '0;
          if (sec == SW'(NSEC - 1)) begin
            bus.out_data  <= y_res;
            bus.out_valid <= 1'b1;
            state         <= OUT;
          end else begin
            sec   <= sec + 1'b1;
            state <= MAC;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Scoreboard bench for iir_biquad_scheduler with two sections; expected outputs are queued at issue
// and popped by an independent monitor on each output handshake.
module tb_iir_biquad_scheduler;
  localparam int W    = 32;
  localparam int NSEC = 2;
  localparam int CA   = $clog2(NSEC * 5);

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] exp_q [$];

  iir_biquad_scheduler_if #(.W(W), .NSEC(NSEC)) bus ();

  iir_biquad_scheduler #(.W(W), .FSW(16), .NSEC(NSEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, $signed(act), act, $signed(req), req);
    end
  endtask

  // Outputs are compared at the falling edge before the handshake edge, so data is settled
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", bus.out_data, 32'hDEAD_BEEF ^ bus.out_data);
      end else begin
        checkOutput("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (!bus.in_ready && n < 400) begin
      tick();
      n++;
    end
    if (!bus.in_ready) checkOutput("in_ready_wait", {31'b0, bus.in_ready}, 1);
  endtask

  task automatic waitInit(output int n);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] sample, input logic [W-1:0] expected);
    waitIdle();
    exp_q.push_back(expected);
    bus.in_valid = 1'b1;
    bus.in_data  = sample;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitOutput(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 400) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) checkOutput("out_valid_wait", {31'b0, bus.out_valid}, 1);
  endtask

  task automatic loadSection(input int s, input logic [W-1:0] b0, input logic [W-1:0] b1,
                             input logic [W-1:0] b2, input logic [W-1:0] a1, input logic [W-1:0] a2);
    logic [W-1:0] c [5];
    c = '{b0, b1, b2, a1, a2};
    waitIdle();
    for (int i = 0; i < 5; i++) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = CA'(s * 5 + i);
      bus.coef_wdata = c[i];
      tick();
      checkOutput("coef_err_legal", {31'b0, bus.coef_err}, 0);
    end
    bus.coef_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int lat;
    int bad;
    logic [W-1:0] held;
    logic [W-1:0] sat_exp;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    repeat (3) tick();

    // Reset values, then INIT must take exactly NSEC cycles
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 0);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_coef_err", {31'b0, bus.coef_err}, 0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 1);
    rst = 1'b0;
    waitInit(n);
    checkOutput("init_cycles", n, NSEC);
    checkOutput("busy_idle", {31'b0, bus.busy}, 0);

    // Identity cascade: latency and pass-through of positive and negative samples
    loadSection(0, 65536, 0, 0, 0, 0);
    loadSection(1, 65536, 0, 0, 0, 0);
    applyStimulus(1000, 1000);
    waitOutput(lat);
    checkOutput("latency", lat, 13);
    applyStimulus(-7, -7);
    waitOutput(lat);

    // Rejected writes: illegal address in IDLE, any address while busy
    waitIdle();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = CA'(NSEC * 5);
    bus.coef_wdata = 32'd12345;
    tick();
    bus.coef_we = 1'b0;
    checkOutput("coef_err_addr", {31'b0, bus.coef_err}, 1);
    applyStimulus(500, 500);
    tick();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    tick();
    bus.coef_we = 1'b0;
    checkOutput("coef_err_busy", {31'b0, bus.coef_err}, 1);
    tick();
    checkOutput("coef_err_pulse_end", {31'b0, bus.coef_err}, 0);
    waitOutput(lat);

    // Write and sample on the same edge: the sample sees b0 = 2.0
    waitIdle();
    exp_q.push_back(2000);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = 32'd131072;
    bus.in_valid   = 1'b1;
    bus.in_data    = 1000;
    tick();
    bus.coef_we  = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("coef_err_simul", {31'b0, bus.coef_err}, 0);
    waitOutput(lat);
    loadSection(0, 65536, 0, 0, 0, 0);

    // Backpressure at OUT: data held, no new sample taken, IDLE right after release
    bus.out_ready = 1'b0;
    applyStimulus(321, 321);
    waitOutput(lat);
    held         = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_data  = 555;
    bad          = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_data !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    checkOutput("hold_bad_cycles", bad, 0);
    checkOutput("held_data", held, 321);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("in_ready_after_release", {31'b0, bus.in_ready}, 1);

    // y = 0.25x + 0.5x1 + 0.25x2 + 0.5y1 on impulse 65536, from cleared state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waitInit(n);
    checkOutput("reinit_cycles", n, NSEC);
    loadSection(0, 16384, 32768, 16384, -32768, 0);
    applyStimulus(65536, 16384);
    applyStimulus(0, 40960);
    applyStimulus(0, 36864);
    applyStimulus(0, 18432);
    applyStimulus(0, 9216);
    waitOutput(lat);

    // Overflow of 2 * 0x7FFF_FFFF in section 0
`ifdef IIR_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'hFFFF_FFFE;
`endif
    loadSection(0, 131072, 0, 0, 0, 0);
    applyStimulus(32'h7FFF_FFFF, sat_exp);
    waitOutput(lat);

    // Reset during MAC discards the sample and reruns INIT
    waitIdle();
    bus.in_valid = 1'b1;
    bus.in_data  = 77;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 0);
    checkOutput("midrst_busy", {31'b0, bus.busy}, 1);
    rst = 1'b0;
    waitInit(n);
    checkOutput("midrst_init_cycles", n, NSEC);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    checkOutput("midrst_no_output", bad, 0);

    repeat (5) tick();
    checkOutput("pending_outputs", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
